// File: rtl/apb_slave_pkg.sv
// apb_slave shared types and sizing.
// Imported by the interface, the storage array and the top level.
package apb_slave_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // An enabled edge moves data only once a SETUP phase has been seen.
  function automatic logic xfer_ok(
    input logic   sel,
    input logic   en,
    input state_t st
  );
    return sel && en && (st != IDLE);
  endfunction

endpackage

// File: rtl/apb_slave_if.sv
// APB bus bundle between the bridge and the scratch slave.
// The bridge drives everything except the read data.
interface apb_slave_if
  import apb_slave_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          p_sel;
  logic          p_en;
  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          p_ready;

  modport master (
    output p_sel,
    output p_en,
    output addr,
    output wr,
    output w_data,
    output p_ready,
    input  r_data
  );

  modport slave (
    input  p_sel,
    input  p_en,
    input  addr,
    input  wr,
    input  w_data,
    input  p_ready,
    output r_data
  );

endinterface

// File: rtl/apb_slave_mem.sv
// Single-port word array with write enable and registered read port.
// Array contents have no reset; only the read register clears.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] w_data,
  output logic [DW-1:0] r_data
);

  localparam int N = 1 << AW;

  logic [DW-1:0] mem_arr [0:N-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_arr[addr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (re) begin
      r_data <= mem_arr[addr];
    end
  end

endmodule

// File: rtl/apb_slave.sv
// Zero-wait APB scratch slave: phase tracking FSM in front of
// a 2^AW x DW storage array.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic        clk,
  input  logic        rst,
  apb_slave_if.slave  bus
);

  state_t        state;
  state_t        state_nxt;
  logic          xfer;
  logic          we;
  logic          re;
  logic [DW-1:0] rd;
  logic          unused_ready;

  // The slave never stalls, so the ready strobe is only observed.
  assign unused_ready = bus.p_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An enable without a prior SETUP is treated as a fresh SETUP.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      !bus.p_sel: begin
        state_nxt = IDLE;
      end
      bus.p_sel && !bus.p_en: begin
        state_nxt = SETUP;
      end
      bus.p_sel && bus.p_en && (state == IDLE): begin
        state_nxt = SETUP;
      end
      bus.p_sel && bus.p_en && (state != IDLE): begin
        state_nxt = ACCESS;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    xfer = xfer_ok(bus.p_sel, bus.p_en, state);
    we   = xfer && bus.wr;
    re   = xfer && !bus.wr;
  end

  apb_slave_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .re     (re),
    .addr   (bus.addr),
    .w_data (bus.w_data),
    .r_data (rd)
  );

  assign bus.r_data = rd;

endmodule

// File: tb/tb_apb_slave.sv
// Directed + randomized bench for apb_slave against a word-array model.
// Inputs change 1ns after the rising edge and outputs are sampled there.
module tb_apb_slave;
  import apb_slave_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [15:0] model [0:255];
  logic [15:0] old_v;
  logic [15:0] d;

  apb_slave_if bus ();

  apb_slave dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.p_sel = 1'b0;
    bus.p_en  = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.p_sel   = 1'b0;
    bus.p_en    = 1'b0;
    bus.addr    = '0;
    bus.wr      = 1'b0;
    bus.w_data  = '0;
    bus.p_ready = 1'b0;
    #1;
    check("reset_rdata", bus.r_data, 16'h0000);
    check("reset_state", 16'(dut.state), 16'(IDLE));
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // single write at 0xEF
    bus.p_sel  = 1'b1;
    bus.wr     = 1'b1;
    bus.addr   = 8'hEF;
    bus.w_data = 16'hABCD;
    cyc();
    check("setup_state", 16'(dut.state), 16'(SETUP));
    bus.p_en = 1'b1;
    cyc();
    model[8'hEF] = 16'hABCD;
    check("single_wr", dut.u_mem.mem_arr[8'hEF], model[8'hEF]);
    check("access_state", 16'(dut.state), 16'(ACCESS));
    check("wr_keeps_rdata", bus.r_data, 16'h0000);
    idle_bus();
    cyc();

    // read back, then async reset between edges
    bus.wr = 1'b0;
    bus.p_sel = 1'b1;
    cyc();
    bus.p_en = 1'b1;
    bus.p_ready = 1'b1;
    cyc();
    check("first_rd", bus.r_data, model[8'hEF]);
    idle_bus();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdata", bus.r_data, 16'h0000);
    check("async_rst_state", 16'(dut.state), 16'(IDLE));
    cyc();
    rst = 1'b0;
    cyc();

    // contents persist across reset
    bus.p_sel = 1'b1;
    bus.addr  = 8'hEF;
    cyc();
    bus.p_en = 1'b1;
    cyc();
    check("persist_rd", bus.r_data, 16'hABCD);
    check("persist_mem", dut.u_mem.mem_arr[8'hEF], 16'hABCD);

    // back-to-back write elsewhere must not disturb r_data
    bus.wr     = 1'b1;
    bus.addr   = 8'h42;
    bus.w_data = 16'h5555;
    cyc();
    model[8'h42] = 16'h5555;
    check("hold_rdata_wr", bus.r_data, 16'hABCD);
    check("hold_mem", dut.u_mem.mem_arr[8'h42], model[8'h42]);
    idle_bus();
    cyc();
    check("hold_state_idle", 16'(dut.state), 16'(IDLE));
    check("hold_rdata_idle", bus.r_data, 16'hABCD);

    // streaming write sweep 0..254
    bus.p_sel = 1'b1;
    bus.wr    = 1'b1;
    bus.addr  = 8'h00;
    cyc();
    bus.p_en = 1'b1;
    for (int a = 0; a < 255; a++) begin
      d = 16'($urandom);
      if (d == 16'h1234) d = 16'h1235;
      bus.addr    = 8'(a);
      bus.w_data  = d;
      bus.p_ready = 1'($urandom);
      cyc();
      model[a] = d;
    end
    check("sweep_mem_0", dut.u_mem.mem_arr[0], model[0]);
    check("sweep_mem_254", dut.u_mem.mem_arr[254], model[254]);
    idle_bus();
    cyc();

    // streaming read sweep
    bus.p_sel = 1'b1;
    bus.wr    = 1'b0;
    bus.addr  = 8'h00;
    cyc();
    bus.p_en = 1'b1;
    for (int a = 0; a < 255; a++) begin
      bus.addr    = 8'(a);
      bus.p_ready = 1'($urandom);
      cyc();
      check($sformatf("sweep_rd_%0d", a), bus.r_data, model[a]);
    end
    idle_bus();
    cyc();

    // reset at the commit edge aborts the write
    old_v = model[8'h20];
    bus.p_sel  = 1'b1;
    bus.wr     = 1'b1;
    bus.addr   = 8'h20;
    bus.w_data = ~old_v;
    cyc();
    bus.p_en = 1'b1;
    rst = 1'b1;
    cyc();
    check("abort_mem", dut.u_mem.mem_arr[8'h20], old_v);
    check("abort_state", 16'(dut.state), 16'(IDLE));
    idle_bus();
    rst = 1'b0;
    cyc();

    // protocol violation: enable without setup
    old_v = model[8'h10];
    bus.p_sel  = 1'b1;
    bus.p_en   = 1'b1;
    bus.wr     = 1'b1;
    bus.addr   = 8'h10;
    bus.w_data = 16'h1234;
    cyc();
    check("viol_no_wr", dut.u_mem.mem_arr[8'h10], old_v);
    check("viol_state", 16'(dut.state), 16'(SETUP));
    cyc();
    model[8'h10] = 16'h1234;
    check("viol_commit", dut.u_mem.mem_arr[8'h10], model[8'h10]);

    // read-after-write on consecutive access edges
    bus.wr = 1'b0;
    cyc();
    check("raw_rd", bus.r_data, model[8'h10]);
    idle_bus();
    cyc();
    check("end_state", 16'(dut.state), 16'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
